scan_decoder: RTL and testbench

Parametrised registered N-to-2^N one-hot decoder with a built-in scan sequencer. In direct mode it latches a select value and drives the matching one-hot output line. In scan mode it steps the active line through 0..last, holding each for a programmable dwell time. It is the next-generation select-line generator for multiplexed displays, keypad row strobing and chip-select fan-out, and replaces purely combinational decoders wherever glitch-free registered strobes or autonomous scanning are needed.

---
 rtl/scan_decoder.sv | 72 +++++++
 tb/tb_scan_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with an autonomous scan sequencer.
// Direct mode latches a select value; scan mode steps 0..last with a fixed dwell per line.
module scan_decoder #(
  parameter int unsigned N     = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      i,
  input  logic [N-1:0]      last,
  output logic [2**N-1:0]   o,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned W      = 2 ** N;
  localparam int unsigned CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DWELL - 1);

  logic [N-1:0]  cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q;
  logic          wrap_q, wrap_d;

  always_comb begin
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (!mode) begin
      cnt_d = '0;
      if (load) cur_d = i;
    end else if (load) begin
      cur_d = i;
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
        // Compare before increment so cur never overflows, and an index above last wraps.
        if (cur_q >= last) begin
          cur_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cur_d = cur_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q  <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      en_q   <= enable;
      wrap_q <= wrap_d;
    end
  end

  assign o    = en_q ? (W'(1) << cur_q) : '0;
  assign idx  = cur_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: three instances (N4/D4, N4/D1, N1/D2) checked every cycle
// against a dwell-time model, plus directed literal expectations.
module tb_scan_decoder;

  logic       clk;
  logic       reset;
  logic       enable, mode, load;
  logic [3:0] i, last;

  logic [15:0] o_m, o_d;
  logic [1:0]  o_n;
  logic [3:0]  idx_m, idx_d;
  logic        idx_n;
  logic        wrap_m, wrap_d, wrap_n;

  int errors = 0;
  int checks = 0;
  bit run = 0;

  // Model state per instance: 0 = N4/D4, 1 = N4/D1, 2 = N1/D2.
  int nb[3]     = '{4, 4, 1};
  int dwell[3]  = '{4, 1, 2};
  int mcur[3]   = '{0, 0, 0};
  int mspent[3] = '{0, 0, 0};
  bit men[3]    = '{0, 0, 0};
  bit mwrap[3]  = '{0, 0, 0};

  scan_decoder #(.N(4), .DWELL(4)) u_main (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
    .i(i), .last(last), .o(o_m), .idx(idx_m), .wrap(wrap_m)
  );

  scan_decoder #(.N(4), .DWELL(1)) u_d1 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
    .i(i), .last(last), .o(o_d), .idx(idx_d), .wrap(wrap_d)
  );

  scan_decoder #(.N(1), .DWELL(2)) u_n1 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
    .i(i[0]), .last(last[0]), .o(o_n), .idx(idx_n), .wrap(wrap_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Each line is held for dwell enabled cycles; past last the scan returns to 0.
  task automatic step(input int k);
    int mask, ii, ll;
    mask     = (1 << nb[k]) - 1;
    ii       = int'(i) & mask;
    ll       = int'(last) & mask;
    men[k]   = enable;
    mwrap[k] = 1'b0;
    if (!mode) begin
      mspent[k] = 0;
      if (load) mcur[k] = ii;
    end else if (load) begin
      mcur[k]   = ii;
      mspent[k] = 0;
    end else if (enable) begin
      mspent[k] = mspent[k] + 1;
      if (mspent[k] == dwell[k]) begin
        mspent[k] = 0;
        if (mcur[k] >= ll) begin
          mcur[k]  = 0;
          mwrap[k] = 1'b1;
        end else begin
          mcur[k] = mcur[k] + 1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      for (int k = 0; k < 3; k++) begin
        if (reset) begin
          mcur[k] = 0; mspent[k] = 0; men[k] = 0; mwrap[k] = 0;
        end else begin
          step(k);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (run && !reset) begin
        for (int k = 0; k < 3; k++) begin
          logic [31:0] eo, go, gi, gw;
          eo = men[k] ? (32'd1 << mcur[k]) : 32'd0;
          case (k)
            0:       begin go = 32'(o_m); gi = 32'(idx_m); gw = 32'(wrap_m); end
            1:       begin go = 32'(o_d); gi = 32'(idx_d); gw = 32'(wrap_d); end
            default: begin go = 32'(o_n); gi = 32'(idx_n); gw = 32'(wrap_n); end
          endcase
          check($sformatf("model_o[%0d]", k), go, eo);
          check($sformatf("model_idx[%0d]", k), gi, 32'(mcur[k]));
          check($sformatf("model_wrap[%0d]", k), gw, 32'(mwrap[k]));
        end
      end
    end
  end

  task automatic cyc(input logic en, input logic md, input logic ld,
                     input logic [3:0] ii, input logic [3:0] la);
    enable = en; mode = md; load = ld; i = ii; last = la;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wraps;
    logic [15:0] acc;
    reset = 1'b1; enable = 1'b0; mode = 1'b0; load = 1'b0; i = '0; last = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run   = 1'b1;
    check("reset_o", 32'(o_m), 32'h0);
    check("reset_idx", 32'(idx_m), 32'h0);
    check("reset_wrap", 32'(wrap_m), 32'h0);

    // Direct decode of every select value.
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'(k), 4'd0);
      if (k == 10) check("direct_i10", 32'(o_m), 32'h0400);
    end
    check("direct_i15", 32'(o_m), 32'h8000);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    check("direct_disable_o", 32'(o_m), 32'h0);
    check("direct_disable_idx", 32'(idx_m), 32'd15);

    // Scan 0..3 with dwell 4.
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 4'd3);
    check("scan_start", 32'(o_m), 32'h0001);
    wraps = 0;
    for (int c = 1; c <= 32; c++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd3);
      wraps += int'(wrap_m);
      if (c == 4)  check("scan_line1", 32'(o_m), 32'h0002);
      if (c == 15) check("scan_line3", 32'(o_m), 32'h0008);
      if (c == 16) check("scan_wrap_o", 32'(o_m), 32'h0001);
      if (c == 16) check("scan_wrap", 32'(wrap_m), 32'h1);
      if (c == 17) check("scan_wrap_once", 32'(wrap_m), 32'h0);
    end
    check("scan_wrap_count", 32'(wraps), 32'd2);

    // Pause at cnt=2 for 3 cycles, then load in the advance cycle.
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd3);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 4'd0, 4'd3);
    check("pause_o", 32'(o_m), 32'h0);
    check("pause_idx", 32'(idx_m), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd3);
    check("pause_extend", 32'(idx_m), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd3);
    check("pause_advance", 32'(idx_m), 32'd1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd3);
    cyc(1'b1, 1'b1, 1'b1, 4'd9, 4'd3);
    check("load_wins", 32'(idx_m), 32'd9);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd3);
    check("load_hold", 32'(idx_m), 32'd9);
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd3);
    check("over_last_idx", 32'(idx_m), 32'd0);
    check("over_last_wrap", 32'(wrap_m), 32'h1);

    // Asynchronous reset mid-scan at index 5.
    cyc(1'b1, 1'b1, 1'b1, 4'd5, 4'd7);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd7);
    check("pre_reset_idx", 32'(idx_m), 32'd5);
    #2 reset = 1'b1;
    #1;
    check("async_reset_o", 32'(o_m), 32'h0);
    check("async_reset_idx", 32'(idx_m), 32'h0);
    check("async_reset_wrap", 32'(wrap_m), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_release_o", 32'(o_m), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd7);
    check("post_release_en", 32'(o_m), 32'h0001);

    // Full scan 0..15.
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 4'd15);
    acc   = o_m;
    wraps = 0;
    for (int c = 1; c <= 64; c++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd15);
      acc   = acc | o_m;
      wraps += int'(wrap_m);
      if (c == 63) check("full_last_line", 32'(o_m), 32'h8000);
      if (c == 32) check("n1_onehot", 32'($onehot(o_n)), 32'h1);
    end
    check("full_all_lines", 32'(acc), 32'hFFFF);
    check("full_wrap_count", 32'(wraps), 32'd1);
    check("full_wrap_end", 32'(wrap_m), 32'h1);

    // DWELL=1 with last=0: wraps on every enabled cycle.
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      check("d1_o", 32'(o_d), 32'h0001);
      check("d1_wrap", 32'(wrap_d), 32'h1);
    end

    // Scan to direct freezes the index.
    cyc(1'b1, 1'b1, 1'b1, 4'd6, 4'd15);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
    check("freeze_idx", 32'(idx_m), 32'd6);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
